// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight store: packs DMA beats into lines for one bank while the MAC side reads the other.
// Optional error reporting (err_o / err_code) is compiled in when WEIGHT_BUF_ERR_EN is defined.
module weight_pingpong_buffer #(
  parameter int WEIGHT_BITS  = 8,
  parameter int N            = 16,
  parameter int MAC_NUM      = 9,
  parameter int DATA_WIDTH   = N * MAC_NUM * WEIGHT_BITS,
  parameter int AXI_WIDTH_DA = 32,
  parameter int DEPTH        = 64,
  parameter int AW           = $clog2(DEPTH),
  parameter int BEATS        = DATA_WIDTH / AXI_WIDTH_DA
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ap_start,
  input  logic [AW:0]             num_lines,
  input  logic [AXI_WIDTH_DA-1:0] dma_data_i,
  input  logic                    dma_vld_i,
  output logic                    dma_rdy_o,
  output logic                    load_done,
  output logic                    ready,
  input  logic                    request,
  input  logic [AW-1:0]           out_ch,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    o_vld,
  input  logic                    release_i,
  output logic                    ap_done
`ifdef WEIGHT_BUF_ERR_EN
  ,
  output logic                    err_o,
  output logic [1:0]              err_code
`endif
);

  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} w_state_t;

  w_state_t              r_state, w_state_next;
  logic                  r_wptr, r_rptr;
  logic [1:0]            r_full;
  logic [AW:0]           r_num_lines, r_line_cnt;
  logic [BCW-1:0]        r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_line_buf;
  logic                  r_wr_en;
  logic [AW-1:0]         r_wr_addr;
  logic                  r_load_done, r_ap_done, r_o_vld, r_rd_bank;
  logic [DATA_WIDTH-1:0] w_rdata [2];

  logic w_beat, w_last_beat, w_rd, w_rel, w_bank_free, w_complete, w_enter_fill;

  assign w_beat      = dma_vld_i & dma_rdy_o;
  assign w_last_beat = w_beat & (r_beat_cnt == BCW'(BEATS - 1));
  assign w_rd        = request & ready;
  assign w_rel       = release_i & ready;
  // A bank released this very cycle counts as free so a waiting load starts without a bubble.
  assign w_bank_free = ~r_full[r_wptr] | (w_rel & (r_rptr == r_wptr));
  // r_line_cnt already counts the line being written, so equality marks the final write.
  assign w_complete   = r_wr_en & (r_line_cnt == r_num_lines);
  assign w_enter_fill = (r_state != W_FILL) & (w_state_next == W_FILL);

  always_comb begin
    w_state_next = r_state;
    dma_rdy_o    = 1'b0;
    case (r_state)
      W_IDLE: if (ap_start) w_state_next = w_bank_free ? W_FILL : W_WAIT;
      W_WAIT: if (w_bank_free) w_state_next = W_FILL;
      W_FILL: begin
        dma_rdy_o = (r_line_cnt != r_num_lines);
        if (w_complete) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= W_IDLE;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_full      <= 2'b00;
      r_num_lines <= '0;
      r_line_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_load_done <= 1'b0;
      r_ap_done   <= 1'b0;
      r_o_vld     <= 1'b0;
      r_rd_bank   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == W_IDLE && ap_start) r_num_lines <= num_lines;
      if (w_enter_fill) begin
        r_line_cnt <= '0;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_line_cnt <= r_line_cnt + 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
      r_wr_en     <= w_last_beat;
      r_wr_addr   <= r_line_cnt[AW-1:0];
      r_load_done <= w_complete;
      // Completion and release always target different banks, so both updates may coincide.
      for (int b = 0; b < 2; b++) begin
        if (w_complete && r_wptr == 1'(b)) r_full[b] <= 1'b1;
        else if (w_rel && r_rptr == 1'(b)) r_full[b] <= 1'b0;
      end
      if (w_complete) r_wptr <= ~r_wptr;
      if (w_rel) r_rptr <= ~r_rptr;
      r_ap_done <= w_rel;
      r_o_vld   <= w_rd;
      if (w_rd) r_rd_bank <= r_rptr;
    end
  end

  // Beat 0 ends up in the LSBs after BEATS right shifts.
  always_ff @(posedge clk) begin
    if (w_beat) r_line_buf <= {dma_data_i, r_line_buf[DATA_WIDTH-1:AXI_WIDTH_DA]};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk) begin
      if (r_wr_en && r_wptr == 1'(gi)) r_mem[r_wr_addr] <= r_line_buf;
      if (w_rd && r_rptr == 1'(gi)) r_rdata <= r_mem[out_ch];
    end
    assign w_rdata[gi] = r_rdata;
  end

  assign ready     = r_full[r_rptr];
  assign load_done = r_load_done;
  assign ap_done   = r_ap_done;
  assign o_vld     = r_o_vld;
  assign dout      = r_o_vld ? w_rdata[r_rd_bank] : '0;

`ifdef WEIGHT_BUF_ERR_EN
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [AW:0] r_bank_lines [2];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err           <= 1'b0;
      r_err_code      <= 2'b00;
      r_bank_lines[0] <= '0;
      r_bank_lines[1] <= '0;
    end else begin
      if (w_complete) r_bank_lines[r_wptr] <= r_num_lines;
      if (!r_err) begin
        if (ap_start && r_state != W_IDLE) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b11;
        end else if (w_rd && {1'b0, out_ch} >= r_bank_lines[r_rptr]) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b10;
        end else if (request && !ready) begin
          r_err      <= 1'b1;
          r_err_code <= 2'b01;
        end
      end
    end
  end

  assign err_o    = r_err;
  assign err_code = r_err_code;
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer (N=4, MAC_NUM=4, DEPTH=8: 128-bit lines of 4 beats).
module tb_weight_pingpong_buffer;
  localparam int DW = 128;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ap_start = 1'b0;
  logic [AW:0]   num_lines = '0;
  logic [31:0]   dma_data_i = '0;
  logic          dma_vld_i = 1'b0;
  logic          dma_rdy_o;
  logic          load_done;
  logic          ready;
  logic          request = 1'b0;
  logic [AW-1:0] out_ch = '0;
  logic [DW-1:0] dout;
  logic          o_vld;
  logic          release_i = 1'b0;
  logic          ap_done;
`ifdef WEIGHT_BUF_ERR_EN
  logic          err_o;
  logic [1:0]    err_code;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  weight_pingpong_buffer #(
    .WEIGHT_BITS(8), .N(4), .MAC_NUM(4), .AXI_WIDTH_DA(32), .DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .ap_start(ap_start), .num_lines(num_lines),
    .dma_data_i(dma_data_i), .dma_vld_i(dma_vld_i), .dma_rdy_o(dma_rdy_o),
    .load_done(load_done), .ready(ready), .request(request), .out_ch(out_ch),
    .dout(dout), .o_vld(o_vld), .release_i(release_i), .ap_done(ap_done)
`ifdef WEIGHT_BUF_ERR_EN
    , .err_o(err_o), .err_code(err_code)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] line_val(input logic [31:0] base, input int l);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v[32*j +: 32] = base + 32'(4 * l + j);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, DW'(dma_rdy_o), 0);
    chk({tag, "_load_done"}, DW'(load_done), 0);
    chk({tag, "_ready"}, DW'(ready), 0);
    chk({tag, "_o_vld"}, DW'(o_vld), 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_ap_done"}, DW'(ap_done), 0);
  endtask

  task automatic start_load(input int n);
    ap_start  = 1'b1;
    num_lines = (AW+1)'(n);
    tick();
    ap_start  = 1'b0;
  endtask

  task automatic feed(input int nbeats, input logic [31:0] base);
    int waited;
    for (int i = 0; i < nbeats; i++) begin
      dma_data_i = base + 32'(i);
      dma_vld_i  = 1'b1;
      waited = 0;
      while (!dma_rdy_o && waited < 50) begin
        tick();
        waited++;
      end
      if (waited >= 50) chk("beat_timeout", DW'(dma_rdy_o), 1);
      tick();
    end
    dma_vld_i = 1'b0;
  endtask

  task automatic finish_load(input bit rel);
    chk("rdy_after_last_beat", DW'(dma_rdy_o), 0);
    chk("load_done_early", DW'(load_done), 0);
    if (rel) release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk("load_done", DW'(load_done), 1);
    chk("ready_after_load", DW'(ready), 1);
    if (rel) chk("ap_done_simul", DW'(ap_done), 1);
    tick();
    chk("load_done_pulse", DW'(load_done), 0);
  endtask

  task automatic rd(input logic [AW-1:0] ch, input logic [DW-1:0] exp, input string tag);
    request = 1'b1;
    out_ch  = ch;
    tick();
    request = 1'b0;
    chk({tag, "_vld"}, DW'(o_vld), 1);
    chk(tag, dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Protocol errors while no bank is full
    request = 1'b1;
    out_ch  = 3'd0;
    tick();
    request = 1'b0;
    chk("req_noready_vld", DW'(o_vld), 0);
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk("rel_noready_ap_done", DW'(ap_done), 0);
    chk("rel_noready_ready", DW'(ready), 0);
`ifdef WEIGHT_BUF_ERR_EN
    chk("err_o", DW'(err_o), 1);
    chk("err_code", DW'(err_code), 1);
`endif

    // Basic load of 2 lines into bank0
    start_load(2);
    chk("fill_rdy", DW'(dma_rdy_o), 1);
    feed(8, 32'h0);
    finish_load(1'b0);
    rd(3'd1, 128'h00000007_00000006_00000005_00000004, "rd_b0_l1");
    tick();
    chk("o_vld_pulse", DW'(o_vld), 0);
    request = 1'b1;
    out_ch  = 3'd0;
    tick();
    chk("b2b_vld0", DW'(o_vld), 1);
    chk("b2b_dout0", dout, line_val(32'h0, 0));
    out_ch = 3'd1;
    tick();
    request = 1'b0;
    chk("b2b_vld1", DW'(o_vld), 1);
    chk("b2b_dout1", dout, line_val(32'h0, 1));
    tick();
    chk("b2b_vld_end", DW'(o_vld), 0);

    // Ping-pong: load bank1 while bank0 is read
    start_load(3);
    rd(3'd1, line_val(32'h0, 1), "ovl_rd_b0");
    feed(12, 32'h100);
    finish_load(1'b0);
    rd(3'd0, line_val(32'h0, 0), "ovl_rd_b0_after");

    // Release with a same-cycle request served from the old bank
    release_i = 1'b1;
    request   = 1'b1;
    out_ch    = 3'd1;
    tick();
    release_i = 1'b0;
    request   = 1'b0;
    chk("rel_ap_done", DW'(ap_done), 1);
    chk("rel_req_vld", DW'(o_vld), 1);
    chk("rel_req_old_bank", dout, line_val(32'h0, 1));
    chk("rel_ready", DW'(ready), 1);
    tick();
    chk("ap_done_pulse", DW'(ap_done), 0);
    rd(3'd2, line_val(32'h100, 2), "rd_b1_l2");

    // Backpressure: both banks full, third load waits
    start_load(2);
    feed(8, 32'h200);
    finish_load(1'b0);
    start_load(1);
    dma_data_i = 32'h300;
    dma_vld_i  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("wait_rdy_low", DW'(dma_rdy_o), 0);
      tick();
    end
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk("bp_ap_done", DW'(ap_done), 1);
    waited = 0;
    while (!dma_rdy_o && waited < 1) begin
      tick();
      waited++;
    end
    chk("bp_rdy_rise", DW'(dma_rdy_o), 1);
    feed(4, 32'h300);
    finish_load(1'b0);
    rd(3'd1, line_val(32'h200, 1), "bp_rd_b0");
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    rd(3'd0, line_val(32'h300, 0), "bp_rd_b1");

    // Full-depth load completing in the same cycle as a release
    start_load(8);
    feed(32, 32'h400);
    finish_load(1'b1);
    rd(3'd7, line_val(32'h400, 7), "depth_rd_l7");
    rd(3'd0, line_val(32'h400, 0), "depth_rd_l0");
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk("both_free_ready", DW'(ready), 0);
    chk("both_free_ap_done", DW'(ap_done), 1);
    request = 1'b1;
    out_ch  = 3'd0;
    tick();
    request = 1'b0;
    chk("empty_req_vld", DW'(o_vld), 0);

    // Reset in the middle of a load
    start_load(2);
    feed(5, 32'h500);
    rstn = 1'b0;
    tick();
    check_reset_outputs("midload_reset");
    rstn = 1'b1;
    tick();
    chk("post_reset_ready", DW'(ready), 0);
    start_load(1);
    feed(4, 32'h600);
    finish_load(1'b0);
    rd(3'd0, line_val(32'h600, 0), "fresh_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
